// File: rtl/sata_pkg.sv
// sata_pkg: definitions shared by the SATA link-layer transmit and receive paths.
//   - txll_state_t : transmit frame-reader state encoding
//   - frame_err_t  : completion status codes reported with frame_done
//   - SATA_CRC_INIT / SATA_CRC_POLY : CRC-32 seed and generator polynomial
//   - TXLL_EOF_BIT : position of the end-of-frame flag in a transmit FIFO word
//   - crc32_step   : one dword of CRC-32 (MSB first, 32 bits per call)
package sata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CRC   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } txll_state_t;

  typedef enum logic [1:0] {
    FERR_OK       = 2'd0,
    FERR_ABORT    = 2'd1,
    FERR_OVERSIZE = 2'd2
  } frame_err_t;

  localparam logic [31:0] SATA_CRC_INIT = 32'h5232_5032;
  localparam logic [31:0] SATA_CRC_POLY = 32'h04C1_1DB7;
  localparam int          TXLL_EOF_BIT  = 34;

  // Bit-serial unrolled CRC update: data bit 31 enters first, no reflection or inversion.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? SATA_CRC_POLY : 32'h0000_0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_crc32.sv
// sata_crc32: combinational next-state of the SATA CRC-32 for one 32-bit dword.
// Ports:
//   crc_in  [31:0] current CRC register value
//   data    [31:0] dword being added to the CRC
//   crc_out [31:0] CRC after absorbing data
module sata_crc32
  import sata_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_step(crc_in, data);

endmodule

// File: rtl/txll_frame_tx.sv
// txll_frame_tx: transmit frame reader sitting behind the transmit FIFO (rd_clk domain).
// Waits for a complete frame in the FIFO, requests the link, streams payload dwords
// under ready/valid, appends the CRC dword and reports completion status. Aborted and
// oversize frames are drained up to their EOF word so no partial frame is left behind.
// Ports:
//   rd_clk, rst      clock, synchronous active-high reset
//   rd_do[35:0]      FIFO head (first-word-fall-through); [31:0] payload, [34] EOF
//   rd_empty         FIFO empty
//   rd_eof_rdy       a whole frame is resident in the FIFO
//   rd_en            FIFO pop (combinational)
//   link_req         request to transmit a frame
//   link_gnt         grant pulse, link has sent SOF
//   link_data[31:0]  payload or CRC dword
//   link_valid       link_data valid
//   link_crc         current beat is the CRC (last) beat
//   link_ready       link accepts the beat this cycle
//   link_abort       far-end abort pulse
//   frame_done       one-cycle end-of-frame pulse
//   frame_err[1:0]   status with frame_done: 0 ok, 1 abort, 2 oversize
//   dw_count[11:0]   payload dwords taken from the FIFO in the current/last frame
module txll_frame_tx
  import sata_pkg::*;
#(
  parameter int          C_MAX_DW   = 2048,
  parameter logic [31:0] C_CRC_INIT = SATA_CRC_INIT
)
(
  input  logic        rd_clk,
  input  logic        rst,
  input  logic [35:0] rd_do,
  input  logic        rd_empty,
  input  logic        rd_eof_rdy,
  output logic        rd_en,
  output logic        link_req,
  input  logic        link_gnt,
  output logic [31:0] link_data,
  output logic        link_valid,
  output logic        link_crc,
  input  logic        link_ready,
  input  logic        link_abort,
  output logic        frame_done,
  output logic [1:0]  frame_err,
  output logic [11:0] dw_count
);

  // A pop at this count without EOF reaches the maximum frame length.
  localparam logic [11:0] MAX_DW_LAST = 12'(C_MAX_DW - 1);

  txll_state_t state_r;
  txll_state_t state_nxt_s;
  logic [31:0] crc_r;
  logic [31:0] crc_nxt_s;
  logic [11:0] dw_count_r;
  frame_err_t  err_r;
  logic        eof_s;
  logic        start_s;
  logic        pop_data_s;
  logic        set_abort_s;
  logic        set_oversize_s;
  logic        head_valid_s;
  logic        unused_s;

  assign eof_s        = rd_do[TXLL_EOF_BIT];
  assign head_valid_s = !rd_empty;
  assign unused_s     = ^{rd_do[35], rd_do[33:32]};
  assign dw_count     = dw_count_r;

  sata_crc32 u_crc (
    .crc_in  (crc_r),
    .data    (rd_do[31:0]),
    .crc_out (crc_nxt_s)
  );

  // State register.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and all state-dependent outputs.
  always_comb begin
    state_nxt_s    = state_r;
    rd_en          = 1'b0;
    link_req       = 1'b0;
    link_data      = 32'h0000_0000;
    link_valid     = 1'b0;
    link_crc       = 1'b0;
    frame_done     = 1'b0;
    frame_err      = FERR_OK;
    start_s        = 1'b0;
    pop_data_s     = 1'b0;
    set_abort_s    = 1'b0;
    set_oversize_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_eof_rdy && head_valid_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        link_req = 1'b1;
        if (link_gnt) begin
          start_s     = 1'b1;
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DATA: begin
        link_data  = rd_do[31:0];
        link_valid = head_valid_s;
        // Abort beats any pop in the same cycle; the drain then consumes that word.
        if (link_abort) begin
          set_abort_s = 1'b1;
          state_nxt_s = ST_DRAIN;
        end else if (head_valid_s && link_ready) begin
          rd_en      = 1'b1;
          pop_data_s = 1'b1;
          if (eof_s) begin
            state_nxt_s = ST_CRC;
          end else if (dw_count_r == MAX_DW_LAST) begin
            set_oversize_s = 1'b1;
            state_nxt_s    = ST_DRAIN;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_CRC: begin
        link_data  = crc_r;
        link_valid = 1'b1;
        link_crc   = 1'b1;
        if (link_abort) begin
          set_abort_s = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (link_ready) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CRC;
        end
      end
      ST_DRAIN: begin
        rd_en = head_valid_s;
        if (head_valid_s && eof_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        frame_done  = 1'b1;
        frame_err   = err_r;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Per-frame CRC accumulator, payload counter and error code.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      crc_r      <= C_CRC_INIT;
      dw_count_r <= 12'd0;
      err_r      <= FERR_OK;
    end else if (start_s) begin
      crc_r      <= C_CRC_INIT;
      dw_count_r <= 12'd0;
      err_r      <= FERR_OK;
    end else begin
      if (pop_data_s) begin
        crc_r <= crc_nxt_s;
        if (dw_count_r != 12'hFFF) begin
          dw_count_r <= dw_count_r + 12'd1;
        end
      end
      if (set_abort_s) begin
        err_r <= FERR_ABORT;
      end else if (set_oversize_s) begin
        err_r <= FERR_OVERSIZE;
      end
    end
  end

endmodule
